// File: rtl/fetch_req_ctrl_if.sv
// Fetch-request bus bundle: PC-register handshake, ICB command/response channels and the IF_ID output.
// The slave modport is the controller side; the master modport is the surrounding pipeline/bus side.
interface fetch_req_ctrl_if #(
    parameter int PC_WIDTH    = 32,
    parameter int INSTR_WIDTH = 32
);
    logic                   fetch_valid_i;
    logic                   fetch_ready_o;
    logic [PC_WIDTH-1:0]    fetch_pc_i;
    logic                   flush_i;
    logic                   icb_cmd_valid_o;
    logic                   icb_cmd_ready_i;
    logic [PC_WIDTH-1:0]    icb_cmd_addr_o;
    logic                   icb_rsp_valid_i;
    logic                   icb_rsp_ready_o;
    logic                   icb_rsp_err_i;
    logic [INSTR_WIDTH-1:0] icb_rsp_rdata_i;
    logic                   if_valid_o;
    logic                   if_ready_i;
    logic [PC_WIDTH-1:0]    if_pc_o;
    logic [INSTR_WIDTH-1:0] if_instr_o;
    logic                   if_excp_misalign_o;
    logic                   if_excp_bus_err_o;

    modport slave (
        input  fetch_valid_i, fetch_pc_i, flush_i, icb_cmd_ready_i, icb_rsp_valid_i,
               icb_rsp_err_i, icb_rsp_rdata_i, if_ready_i,
        output fetch_ready_o, icb_cmd_valid_o, icb_cmd_addr_o, icb_rsp_ready_o,
               if_valid_o, if_pc_o, if_instr_o, if_excp_misalign_o, if_excp_bus_err_o
    );

    modport master (
        output fetch_valid_i, fetch_pc_i, flush_i, icb_cmd_ready_i, icb_rsp_valid_i,
               icb_rsp_err_i, icb_rsp_rdata_i, if_ready_i,
        input  fetch_ready_o, icb_cmd_valid_o, icb_cmd_addr_o, icb_rsp_ready_o,
               if_valid_o, if_pc_o, if_instr_o, if_excp_misalign_o, if_excp_bus_err_o
    );
endinterface

// File: rtl/fetch_req_ctrl.sv
// Instruction fetch sequencer: pipelined ICB commands, in-order PC FIFO, flush drop and exceptions.
// Optional macro FETCH_REQ_CTRL_RSP_BYPASS_EN forwards a response straight to IF_ID when the out register is empty.
module fetch_req_ctrl #(
    parameter int PC_WIDTH    = 32,
    parameter int INSTR_WIDTH = 32,
    parameter int MAX_OST     = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    fetch_req_ctrl_if.slave   bus
);
    localparam int PTR_W = (MAX_OST > 1) ? $clog2(MAX_OST) : 1;
    localparam int CNT_W = $clog2(MAX_OST + 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OST);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OST - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DROP, MISA} state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       ost_cnt_q, ost_cnt_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PC_WIDTH-1:0]    pc_fifo_q [MAX_OST];

    logic                   out_vld_q, out_vld_d;
    logic [PC_WIDTH-1:0]    out_pc_q, out_pc_d;
    logic [INSTR_WIDTH-1:0] out_instr_q, out_instr_d;
    logic                   out_misa_q, out_misa_d;
    logic                   out_err_q, out_err_d;

    logic                   aligned, cmd_valid, cmd_hs, misa_acc;
    logic                   rsp_ready, rsp_hs, rsp_keep, byp, byp_taken;
    logic [PC_WIDTH-1:0]    head_pc;
    logic [INSTR_WIDTH-1:0] rsp_instr;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign head_pc   = pc_fifo_q[rd_ptr_q];
    assign rsp_instr = bus.icb_rsp_err_i ? '0 : bus.icb_rsp_rdata_i;
    assign aligned   = (bus.fetch_pc_i[1:0] == 2'b00);

    assign cmd_valid = bus.fetch_valid_i & aligned & (ost_cnt_q < MAX_CNT) &
                       (state_q != DROP) & (state_q != MISA) & ~bus.flush_i;
    assign cmd_hs    = cmd_valid & bus.icb_cmd_ready_i;
    // A misaligned PC never reaches the bus; it lands in the out register at the accepting edge.
    assign misa_acc  = bus.fetch_valid_i & ~aligned & (state_q == IDLE) &
                       (~out_vld_q | bus.if_ready_i) & ~bus.flush_i;

    // Never ready with nothing outstanding, so stray responses are ignored.
    assign rsp_ready = (ost_cnt_q != '0) & ((state_q == DROP) | ~out_vld_q | bus.if_ready_i);
    assign rsp_hs    = bus.icb_rsp_valid_i & rsp_ready;
    assign rsp_keep  = rsp_hs & ~bus.flush_i & (state_q != DROP);

`ifdef FETCH_REQ_CTRL_RSP_BYPASS_EN
    assign byp       = rsp_keep & ~out_vld_q;
`else
    assign byp       = 1'b0;
`endif
    assign byp_taken = byp & bus.if_ready_i;

    always_comb begin
        ost_cnt_d = ost_cnt_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (cmd_hs) wr_ptr_d = next_ptr(wr_ptr_q);
        if (rsp_hs) rd_ptr_d = next_ptr(rd_ptr_q);
        if (cmd_hs && !rsp_hs)      ost_cnt_d = ost_cnt_q + 1'b1;
        else if (!cmd_hs && rsp_hs) ost_cnt_d = ost_cnt_q - 1'b1;
    end

    always_comb begin
        state_d = state_q;
        if (bus.flush_i) begin
            state_d = (ost_cnt_d != '0) ? DROP : IDLE;
        end else begin
            case (state_q)
                DROP:       if (ost_cnt_d == '0) state_d = IDLE;
                MISA:       state_d = IDLE;
                IDLE, BUSY: if (misa_acc) state_d = MISA;
                            else          state_d = (ost_cnt_d != '0) ? BUSY : IDLE;
                default:    state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        out_vld_d   = out_vld_q;
        out_pc_d    = out_pc_q;
        out_instr_d = out_instr_q;
        out_misa_d  = out_misa_q;
        out_err_d   = out_err_q;
        if (bus.flush_i) begin
            out_vld_d = 1'b0;
        end else if (misa_acc) begin
            out_vld_d   = 1'b1;
            out_pc_d    = bus.fetch_pc_i;
            out_instr_d = '0;
            out_misa_d  = 1'b1;
            out_err_d   = 1'b0;
        end else if (rsp_keep && !byp_taken) begin
            out_vld_d   = 1'b1;
            out_pc_d    = head_pc;
            out_instr_d = rsp_instr;
            out_misa_d  = 1'b0;
            out_err_d   = bus.icb_rsp_err_i;
        end else if (bus.if_ready_i) begin
            out_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            ost_cnt_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            out_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ost_cnt_q <= ost_cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            out_vld_q <= out_vld_d;
        end
    end

    // Datapath registers carry no reset; outputs are qualified by out_vld_q instead.
    always_ff @(posedge clk_i) begin
        if (cmd_hs) pc_fifo_q[wr_ptr_q] <= bus.fetch_pc_i;
        out_pc_q    <= out_pc_d;
        out_instr_q <= out_instr_d;
        out_misa_q  <= out_misa_d;
        out_err_q   <= out_err_d;
    end

    assign bus.icb_cmd_valid_o = cmd_valid;
    assign bus.icb_cmd_addr_o  = bus.fetch_pc_i;
    assign bus.fetch_ready_o   = cmd_hs | misa_acc;
    assign bus.icb_rsp_ready_o = rsp_ready;

    always_comb begin
        if (byp) begin
            bus.if_valid_o         = 1'b1;
            bus.if_pc_o            = head_pc;
            bus.if_instr_o         = rsp_instr;
            bus.if_excp_misalign_o = 1'b0;
            bus.if_excp_bus_err_o  = bus.icb_rsp_err_i;
        end else begin
            bus.if_valid_o         = out_vld_q;
            bus.if_pc_o            = out_vld_q ? out_pc_q : '0;
            bus.if_instr_o         = out_vld_q ? out_instr_q : '0;
            bus.if_excp_misalign_o = out_vld_q & out_misa_q;
            bus.if_excp_bus_err_o  = out_vld_q & out_err_q;
        end
    end
endmodule

// File: tb/tb_fetch_req_ctrl.sv
// Directed bench for fetch_req_ctrl: stream, backpressure, flush, misalign, bus error and response latency.
module tb_fetch_req_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fetch_req_ctrl_if #(.PC_WIDTH(32), .INSTR_WIDTH(32)) bus ();

    fetch_req_ctrl #(.PC_WIDTH(32), .INSTR_WIDTH(32), .MAX_OST(2)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.fetch_valid_i   = 1'b0;
        bus.fetch_pc_i      = '0;
        bus.flush_i         = 1'b0;
        bus.icb_cmd_ready_i = 1'b0;
        bus.icb_rsp_valid_i = 1'b0;
        bus.icb_rsp_err_i   = 1'b0;
        bus.icb_rsp_rdata_i = '0;
        bus.if_ready_i      = 1'b0;
        tick();
        tick();
        chk("rst_if_valid", 32'(bus.if_valid_o), 32'd0);
        chk("rst_cmd_valid", 32'(bus.icb_cmd_valid_o), 32'd0);
        chk("rst_rsp_ready", 32'(bus.icb_rsp_ready_o), 32'd0);
        chk("rst_fetch_ready", 32'(bus.fetch_ready_o), 32'd0);
        chk("rst_if_pc", bus.if_pc_o, 32'd0);
        chk("rst_if_instr", bus.if_instr_o, 32'd0);
        rst = 1'b0;
        bus.icb_cmd_ready_i = 1'b1;
        bus.if_ready_i      = 1'b1;
        tick();

        // Stream 0x0, 0x4, 0x8 with a one-cycle bus.
        bus.fetch_valid_i = 1'b1; bus.fetch_pc_i = 32'h0; #1;
        chk("str_cmd_valid0", 32'(bus.icb_cmd_valid_o), 32'd1);
        chk("str_fetch_ready0", 32'(bus.fetch_ready_o), 32'd1);
        chk("str_cmd_addr0", bus.icb_cmd_addr_o, 32'h0);
        tick();
        bus.fetch_pc_i = 32'h4; bus.icb_rsp_valid_i = 1'b1; bus.icb_rsp_rdata_i = 32'h1111; #1;
        chk("str_rsp_ready", 32'(bus.icb_rsp_ready_o), 32'd1);
        chk("str_cmd_valid1", 32'(bus.icb_cmd_valid_o), 32'd1);
        tick();
        bus.fetch_pc_i = 32'h8; bus.icb_rsp_rdata_i = 32'h2222; #1;
        chk("str_if_valid0", 32'(bus.if_valid_o), 32'd1);
        chk("str_if_pc0", bus.if_pc_o, 32'h0);
        chk("str_if_instr0", bus.if_instr_o, 32'h1111);
        tick();
        bus.fetch_valid_i = 1'b0; bus.icb_rsp_rdata_i = 32'h3333; #1;
        chk("str_if_pc1", bus.if_pc_o, 32'h4);
        chk("str_if_instr1", bus.if_instr_o, 32'h2222);
        tick();
        bus.icb_rsp_valid_i = 1'b0; #1;
        chk("str_if_pc2", bus.if_pc_o, 32'h8);
        chk("str_if_instr2", bus.if_instr_o, 32'h3333);
        chk("str_rsp_ready_idle", 32'(bus.icb_rsp_ready_o), 32'd0);
        tick();
        chk("str_drained", 32'(bus.if_valid_o), 32'd0);

        // Backpressure: entry 0x40 held while 0x44/0x48 are outstanding.
        bus.fetch_valid_i = 1'b1; bus.fetch_pc_i = 32'h40;
        tick();
        bus.fetch_pc_i = 32'h44; bus.icb_rsp_valid_i = 1'b1; bus.icb_rsp_rdata_i = 32'hA0;
        tick();
        bus.fetch_pc_i = 32'h48; bus.icb_rsp_valid_i = 1'b0; bus.if_ready_i = 1'b0;
        tick();
        bus.fetch_pc_i = 32'h4C; bus.icb_rsp_valid_i = 1'b1; bus.icb_rsp_rdata_i = 32'hA4;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_if_valid", 32'(bus.if_valid_o), 32'd1);
            chk("bp_if_pc", bus.if_pc_o, 32'h40);
            chk("bp_if_instr", bus.if_instr_o, 32'hA0);
            chk("bp_rsp_ready", 32'(bus.icb_rsp_ready_o), 32'd0);
            chk("bp_no_third_cmd", 32'(bus.icb_cmd_valid_o), 32'd0);
            tick();
        end
        bus.fetch_valid_i = 1'b0; bus.if_ready_i = 1'b1; #1;
        chk("bp_release_rsp_ready", 32'(bus.icb_rsp_ready_o), 32'd1);
        tick();
        bus.icb_rsp_rdata_i = 32'hA8; #1;
        chk("bp_if_pc1", bus.if_pc_o, 32'h44);
        chk("bp_if_instr1", bus.if_instr_o, 32'hA4);
        tick();
        bus.icb_rsp_valid_i = 1'b0; #1;
        chk("bp_if_pc2", bus.if_pc_o, 32'h48);
        chk("bp_if_instr2", bus.if_instr_o, 32'hA8);
        tick();

        // Flush with two outstanding; both responses dropped, 0x100 issued afterwards.
        bus.fetch_valid_i = 1'b1; bus.fetch_pc_i = 32'h80;
        tick();
        bus.fetch_pc_i = 32'h84;
        tick();
        bus.fetch_pc_i = 32'h100; bus.flush_i = 1'b1; #1;
        chk("fl_cmd_blocked", 32'(bus.icb_cmd_valid_o), 32'd0);
        tick();
        bus.flush_i = 1'b0; bus.icb_rsp_valid_i = 1'b1; bus.icb_rsp_rdata_i = 32'hDEAD; #1;
        chk("fl_drop_rsp_ready0", 32'(bus.icb_rsp_ready_o), 32'd1);
        chk("fl_drop_no_cmd0", 32'(bus.icb_cmd_valid_o), 32'd0);
        chk("fl_if_valid0", 32'(bus.if_valid_o), 32'd0);
        tick();
        bus.icb_rsp_rdata_i = 32'hBEEF; #1;
        chk("fl_drop_rsp_ready1", 32'(bus.icb_rsp_ready_o), 32'd1);
        chk("fl_drop_no_cmd1", 32'(bus.icb_cmd_valid_o), 32'd0);
        chk("fl_if_valid1", 32'(bus.if_valid_o), 32'd0);
        tick();
        bus.icb_rsp_valid_i = 1'b0; #1;
        chk("fl_if_valid2", 32'(bus.if_valid_o), 32'd0);
        chk("fl_reissue_valid", 32'(bus.icb_cmd_valid_o), 32'd1);
        chk("fl_reissue_addr", bus.icb_cmd_addr_o, 32'h100);
        tick();
        bus.fetch_valid_i = 1'b0; bus.icb_rsp_valid_i = 1'b1; bus.icb_rsp_rdata_i = 32'h5555;
        tick();
        bus.icb_rsp_valid_i = 1'b0; #1;
        chk("fl_after_pc", bus.if_pc_o, 32'h100);
        chk("fl_after_instr", bus.if_instr_o, 32'h5555);
        tick();

        // Flush coinciding with the only response: discarded, straight back to IDLE.
        bus.fetch_valid_i = 1'b1; bus.fetch_pc_i = 32'h200;
        tick();
        bus.fetch_valid_i = 1'b0; bus.flush_i = 1'b1; bus.icb_rsp_valid_i = 1'b1;
        bus.icb_rsp_rdata_i = 32'h99;
        tick();
        bus.flush_i = 1'b0; bus.icb_rsp_valid_i = 1'b0;
        bus.fetch_valid_i = 1'b1; bus.fetch_pc_i = 32'h204; #1;
        chk("flr_if_valid", 32'(bus.if_valid_o), 32'd0);
        chk("flr_idle_issue", 32'(bus.icb_cmd_valid_o), 32'd1);
        tick();
        bus.fetch_valid_i = 1'b0; bus.icb_rsp_valid_i = 1'b1; bus.icb_rsp_rdata_i = 32'h204;
        tick();
        bus.icb_rsp_valid_i = 1'b0;
        tick();

        // Misaligned PC 0x6 in IDLE.
        bus.fetch_valid_i = 1'b1; bus.fetch_pc_i = 32'h6; #1;
        chk("mis_no_cmd", 32'(bus.icb_cmd_valid_o), 32'd0);
        chk("mis_fetch_ready", 32'(bus.fetch_ready_o), 32'd1);
        tick();
        bus.fetch_pc_i = 32'h10; #1;
        chk("mis_if_valid", 32'(bus.if_valid_o), 32'd1);
        chk("mis_if_pc", bus.if_pc_o, 32'h6);
        chk("mis_flag", 32'(bus.if_excp_misalign_o), 32'd1);
        chk("mis_instr", bus.if_instr_o, 32'h0);
        chk("mis_blocks_issue", 32'(bus.icb_cmd_valid_o), 32'd0);
        tick();
        bus.fetch_valid_i = 1'b0; #1;
        chk("mis_cleared", 32'(bus.if_valid_o), 32'd0);

        // Bus error on PC 0x20.
        bus.fetch_valid_i = 1'b1; bus.fetch_pc_i = 32'h20;
        tick();
        bus.fetch_valid_i = 1'b0; bus.if_ready_i = 1'b0;
        bus.icb_rsp_valid_i = 1'b1; bus.icb_rsp_err_i = 1'b1; bus.icb_rsp_rdata_i = 32'h13;
        tick();
        bus.icb_rsp_valid_i = 1'b0; bus.icb_rsp_err_i = 1'b0; #1;
        chk("err_if_valid", 32'(bus.if_valid_o), 32'd1);
        chk("err_if_pc", bus.if_pc_o, 32'h20);
        chk("err_flag", 32'(bus.if_excp_bus_err_o), 32'd1);
        chk("err_instr", bus.if_instr_o, 32'h0);
        chk("err_no_misalign", 32'(bus.if_excp_misalign_o), 32'd0);
        bus.if_ready_i = 1'b1;
        tick();

        // Response latency into an empty out register.
        bus.fetch_valid_i = 1'b1; bus.fetch_pc_i = 32'h30;
        tick();
        bus.fetch_valid_i = 1'b0; bus.icb_rsp_valid_i = 1'b1; bus.icb_rsp_rdata_i = 32'h77; #1;
`ifdef FETCH_REQ_CTRL_RSP_BYPASS_EN
        chk("lat_same_cycle_valid", 32'(bus.if_valid_o), 32'd1);
        chk("lat_same_cycle_pc", bus.if_pc_o, 32'h30);
`else
        chk("lat_same_cycle_valid", 32'(bus.if_valid_o), 32'd0);
`endif
        tick();
        bus.icb_rsp_valid_i = 1'b0; #1;
`ifdef FETCH_REQ_CTRL_RSP_BYPASS_EN
        chk("lat_next_cycle_valid", 32'(bus.if_valid_o), 32'd0);
`else
        chk("lat_next_cycle_valid", 32'(bus.if_valid_o), 32'd1);
        chk("lat_next_cycle_pc", bus.if_pc_o, 32'h30);
        chk("lat_next_cycle_instr", bus.if_instr_o, 32'h77);
`endif
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
